axil_read_arbiter: RTL and testbench
====================================

# axil_read_arbiter

Round-robin arbiter that shares one AXI4-Lite read master port (AR and R channels) between NUM_REQ requesters. It sits upstream of the read-data master/slave channel stages and sequences one read transaction at a time: address phase, then data phase. It returns each response only to the requester that issued the read. Only one read is in flight at any time, so response routing needs no ID tracking.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  asynchronous reset, active-high
- req_arvalid  in  NUM_REQ  per-requester read request
- req_araddr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_arready  out  NUM_REQ  per-requester address accept
- req_rvalid  out  NUM_REQ  per-requester read data valid
- req_rready  in  NUM_REQ  per-requester read data ready
- req_rdata  out  DATA_W  shared read data, meaningful only with req_rvalid
- req_rresp  out  2  shared response, meaningful only with req_rvalid
- M_ARVALID  out  1  master address valid
- M_ARADDR  out  ADDR_W  master address
- M_ARREADY  in  1  master address ready
- M_RVALID  in  1  master read valid
- M_RREADY  out  1  master read ready
- M_RDATA  in  DATA_W  master read data
- M_RRESP  in  2  master read response
- busy  out  1  high when state is not IDLE
- grant_id  out  clog2(NUM_REQ)  index of current or last granted requester

## Operation
- FSM states are IDLE, ADDR and DATA; the encoding is 2 bits.
- IDLE:
  - If any req_arvalid is high, choose grant g by round robin: the first set bit searching upward from last_grant+1 and wrapping modulo NUM_REQ.
  - Drive req_arready[g]=1 combinationally in the same cycle.
  - On that edge, register M_ARADDR <= req_araddr[g] and grant_id <= g, then go to ADDR.
  - Only one req_arready bit may be high in any cycle.
- ADDR:
  - M_ARVALID=1. M_ARADDR stays stable until the handshake.
  - On M_ARVALID && M_ARREADY, go to DATA.
- DATA:
  - req_rvalid[g] = M_RVALID and M_RREADY = req_rready[g], both combinational.
  - req_rdata and req_rresp pass through from M_RDATA and M_RRESP, both combinational.
  - All other req_rvalid bits are 0.
  - On M_RVALID && M_RREADY: last_grant <= g, go to IDLE.
- Outside DATA: M_RREADY=0, all req_rvalid=0, req_rdata=0, req_rresp=0.
- Responses are forwarded unmodified; SLVERR and DECERR are passed to the requester, not retried.
- A requester must hold req_arvalid and req_araddr until it sees req_arready. A request that drops req_arvalid before grant is simply not served.

## Timing
- Reset values: state=IDLE, M_ARVALID=0, M_ARADDR=0, grant_id=0, busy=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
- Asserting ARESETn mid-transaction abandons it. Outputs go to reset values immediately, without waiting for ACLK.
- Minimum latency, with M_ARREADY and M_RVALID both high on arrival:
  - cycle 0: req_arvalid/req_arready handshake
  - cycle 1: M_ARVALID high and accepted
  - cycle 2: DATA phase, req_rvalid high
  - cycle 3: back in IDLE, next grant possible
- Back-to-back throughput is therefore one read per 3 cycles.
- Simultaneous requests: exactly one is granted per IDLE cycle. A requester that was just served has lowest priority next time.
- A held M_ARREADY=0 or M_RVALID=0 stalls indefinitely; there is no timeout. Requests from other requesters wait, with req_arready low.
- req_rready low in DATA stalls the master: M_RREADY stays low and the R beat is held by the master.

## Structure
- Shared package axil_pkg holds:
  - state typedef {IDLE, ADDR, DATA}
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
- Sub-module rr_pick(NUM_REQ) is combinational. It takes request vector and last_grant and outputs a one-hot grant plus an index. It is reusable by a later write-channel arbiter.
- The top level contains the FSM, the address register and the R-channel steering.

## Test plan
- Single request: req_arvalid=01, addr 0x0000_1000, M_ARREADY=1, M_RDATA=0xDEADBEEF, OKAY. Required: M_ARADDR=0x1000 in cycle 1; req_rvalid=01 with 0xDEADBEEF in cycle 2.
- Contention: both requesters hold requests for 4 transactions. Required grant order is 0,1,0,1; each req_arready pulses once per grant.
- Stalls: M_ARREADY low for 5 cycles, then req_rready[g] low for 3 cycles. Required: M_ARADDR stable throughout; M_RREADY mirrors req_rready; no data is lost.
- Error pass-through: M_RRESP=2'b10 with data 0x0. Required: req_rresp=2'b10 delivered to the granted requester only.
- Reset mid-DATA: ARESETn asserted while M_RVALID=1. Required: same-cycle M_ARVALID=0, M_RREADY=0, busy=0; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite arbiter definitions: read FSM state encoding and response codes.
package axil_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_read_arbiter_if.sv
// Requester-side and master-side AR/R channel bundle of the read arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface axil_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);

    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ-1:0]        req_arready;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [NUM_REQ-1:0]        req_rready;
    logic [DATA_W-1:0]         req_rdata;
    logic [1:0]                req_rresp;

    logic                      M_ARVALID;
    logic [ADDR_W-1:0]         M_ARADDR;
    logic                      M_ARREADY;
    logic                      M_RVALID;
    logic                      M_RREADY;
    logic [DATA_W-1:0]         M_RDATA;
    logic [1:0]                M_RRESP;

    modport master (
        input  req_arvalid, req_araddr, req_rready,
        input  M_ARREADY, M_RVALID, M_RDATA, M_RRESP,
        output req_arready, req_rvalid, req_rdata, req_rresp,
        output M_ARVALID, M_ARADDR, M_RREADY
    );

    modport slave (
        output req_arvalid, req_araddr, req_rready,
        output M_ARREADY, M_RVALID, M_RDATA, M_RRESP,
        input  req_arready, req_rvalid, req_rdata, req_rresp,
        input  M_ARVALID, M_ARADDR, M_RREADY
    );

endinterface

// File: rtl/axil_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from
// last_grant+1, wrapping modulo NUM_REQ. Shared by the read and write arbiters.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Rotating priority search; the requester just served is visited last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        any = found_s;
    end

endmodule

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read master port between NUM_REQ
// requesters, one transaction (address phase then data phase) in flight at a time.
module axil_read_arbiter
    import axil_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    axil_read_arbiter_if.master        bus,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [ADDR_W-1:0]  araddr_r;
    logic [ADDR_W-1:0]  araddr_sel_s;
    logic [IDX_W-1:0]   grant_r;
    logic [IDX_W-1:0]   last_r;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0] pick_grant_s;
    logic               pick_any_s;
    logic [NUM_REQ-1:0] arready_s;
    logic [NUM_REQ-1:0] rvalid_s;
    logic               load_s;
    logic               done_s;
    logic               m_arvalid_s;
    logic               m_rready_s;
    logic [DATA_W-1:0]  rdata_s;
    logic [1:0]         rresp_s;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req_arvalid),
        .last_grant (last_r),
        .grant      (pick_grant_s),
        .grant_idx  (pick_idx_s),
        .any        (pick_any_s)
    );

    // One-hot address mux driven by the picker's grant
    always_comb begin
        araddr_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            araddr_sel_s = araddr_sel_s
                         | (bus.req_araddr[i*ADDR_W +: ADDR_W] & {ADDR_W{pick_grant_s[i]}});
        end
    end

    // Next-state and channel steering; R signals stay quiet outside DATA
    always_comb begin
        next_state_s = state_r;
        arready_s    = '0;
        load_s       = 1'b0;
        done_s       = 1'b0;
        m_arvalid_s  = 1'b0;
        m_rready_s   = 1'b0;
        rvalid_s     = '0;
        rdata_s      = '0;
        rresp_s      = RESP_OKAY;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    arready_s    = pick_grant_s;
                    load_s       = 1'b1;
                    next_state_s = ADDR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ADDR: begin
                m_arvalid_s = 1'b1;
                if (bus.M_ARREADY) begin
                    next_state_s = DATA;
                end else begin
                    next_state_s = ADDR;
                end
            end
            DATA: begin
                rvalid_s[grant_r] = bus.M_RVALID;
                m_rready_s        = bus.req_rready[grant_r];
                rdata_s           = bus.M_RDATA;
                rresp_s           = bus.M_RRESP;
                if (bus.M_RVALID && m_rready_s) begin
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DATA;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, captured address/grant, and round-robin pointer
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state_r  <= IDLE;
            araddr_r <= '0;
            grant_r  <= '0;
            last_r   <= LAST_INIT;
        end else begin
            state_r <= next_state_s;
            if (load_s) begin
                araddr_r <= araddr_sel_s;
                grant_r  <= pick_idx_s;
            end
            if (done_s) begin
                last_r <= grant_r;
            end
        end
    end

    assign bus.req_arready = arready_s;
    assign bus.req_rvalid  = rvalid_s;
    assign bus.req_rdata   = rdata_s;
    assign bus.req_rresp   = rresp_s;
    assign bus.M_ARVALID   = m_arvalid_s;
    assign bus.M_ARADDR    = araddr_r;
    assign bus.M_RREADY    = m_rready_s;
    assign busy            = (state_r != IDLE);
    assign grant_id        = grant_r;

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Self-checking bench for axil_read_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin reference model.
module tb_axil_read_arbiter;
    import axil_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          busy;
    logic [IW-1:0] grant_id;

    int errors = 0;
    int checks = 0;

    axil_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axil_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK     (aclk),
        .ARESETn  (aresetn),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference rule: first requester set searching upward from last+1, wrapping.
    function automatic int rr_expect(logic [N-1:0] p, int lg);
        for (int k = 1; k <= N; k++) begin
            if (p[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.req_arvalid = '0;
        bus.req_araddr  = '0;
        bus.req_rready  = '0;
        bus.M_ARREADY   = 1'b0;
        bus.M_RVALID    = 1'b0;
        bus.M_RDATA     = '0;
        bus.M_RRESP     = 2'b00;
    endtask

    task automatic test_reset();
        clear_inputs();
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.M_ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", bus.M_ARVALID); end
        checks++; if (bus.M_ARADDR !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h want 0", bus.M_ARADDR); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (bus.M_RREADY !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", bus.M_RREADY); end
        @(negedge aclk);
        aresetn = 1'b0;
    endtask

    task automatic test_contention();
        int exp_order [4] = '{0, 1, 0, 1};
        int pulses [N];
        logic [N-1:0] expv;
        for (int i = 0; i < N; i++) pulses[i] = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge aclk);
            if (cyc == 0) begin
                bus.req_arvalid = 3'b011;
                bus.req_araddr  = {32'h0, 32'h0000_0200, 32'h0000_0100};
                bus.M_ARREADY   = 1'b1;
                bus.M_RVALID    = 1'b1;
                bus.req_rready  = 3'b111;
            end
            bus.M_RDATA = $urandom;
            #1;
            for (int i = 0; i < N; i++) pulses[i] += int'(bus.req_arready[i]);
            expv = '0;
            expv[exp_order[cyc / 3]] = 1'b1;
            case (cyc % 3)
                0: begin
                    checks++; if (bus.req_arready !== expv) begin errors++; $display("FAIL contention_arready t%0d: got %b want %b", cyc / 3, bus.req_arready, expv); end
                end
                1: begin
                    checks++; if (grant_id !== IW'(exp_order[cyc / 3])) begin errors++; $display("FAIL contention_grant t%0d: got %0d want %0d", cyc / 3, grant_id, exp_order[cyc / 3]); end
                end
                default: begin
                    checks++; if (bus.req_rvalid !== expv) begin errors++; $display("FAIL contention_rvalid t%0d: got %b want %b", cyc / 3, bus.req_rvalid, expv); end
                end
            endcase
        end
        @(negedge aclk);
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            checks++; if (pulses[i] !== 2) begin errors++; $display("FAIL contention_pulses req%0d: got %0d want 2", i, pulses[i]); end
        end
    endtask

    task automatic test_single();
        @(negedge aclk);
        bus.req_arvalid = 3'b001;
        bus.req_araddr  = {32'h0, 32'h0, 32'h0000_1000};
        bus.M_ARREADY   = 1'b1;
        bus.M_RVALID    = 1'b1;
        bus.M_RDATA     = 32'hDEAD_BEEF;
        bus.M_RRESP     = RESP_OKAY;
        bus.req_rready  = 3'b111;
        #1;
        checks++; if (bus.req_arready !== 3'b001) begin errors++; $display("FAIL single_arready: got %b want 001", bus.req_arready); end
        @(negedge aclk);
        bus.req_arvalid = 3'b000;
        #1;
        checks++; if (bus.M_ARVALID !== 1'b1 || bus.M_ARADDR !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got v=%b a=%h want v=1 a=00001000", bus.M_ARVALID, bus.M_ARADDR); end
        @(negedge aclk);
        #1;
        checks++; if (bus.req_rvalid !== 3'b001) begin errors++; $display("FAIL single_rvalid: got %b want 001", bus.req_rvalid); end
        checks++; if (bus.req_rdata !== 32'hDEAD_BEEF || bus.req_rresp !== RESP_OKAY) begin errors++; $display("FAIL single_rdata: got %h/%b want deadbeef/00", bus.req_rdata, bus.req_rresp); end
        @(negedge aclk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
        clear_inputs();
    endtask

    task automatic test_stalls();
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge aclk);
            if (cyc == 0) begin
                bus.req_arvalid = 3'b100;
                bus.req_araddr  = {32'hCAFE_0004, 32'h0, 32'h0};
                bus.req_rready  = 3'b111;
            end else if (cyc == 1) begin
                bus.req_arvalid = 3'b001;
                bus.req_araddr  = {32'h0BAD_0002, 32'h0, 32'h0BAD_0000};
            end else if (cyc == 6) begin
                bus.req_arvalid = 3'b000;
                bus.M_ARREADY   = 1'b1;
            end else if (cyc == 7) begin
                bus.M_ARREADY   = 1'b0;
                bus.M_RVALID    = 1'b1;
                bus.M_RDATA     = 32'h1234_5678;
                bus.req_rready  = 3'b011;
            end else if (cyc == 10) begin
                bus.req_rready  = 3'b111;
            end
            #1;
            if (cyc == 0) begin
                checks++; if (bus.req_arready !== 3'b100) begin errors++; $display("FAIL stall_grant: got %b want 100", bus.req_arready); end
            end else if (cyc <= 6) begin
                checks++; if (bus.M_ARVALID !== 1'b1 || bus.M_ARADDR !== 32'hCAFE_0004) begin errors++; $display("FAIL stall_addr c%0d: got v=%b a=%h want v=1 a=cafe0004", cyc, bus.M_ARVALID, bus.M_ARADDR); end
                checks++; if (bus.req_arready !== 3'b000) begin errors++; $display("FAIL stall_no_arready c%0d: got %b want 000", cyc, bus.req_arready); end
            end else if (cyc <= 10) begin
                checks++; if (bus.M_RREADY !== (cyc == 10)) begin errors++; $display("FAIL stall_rready c%0d: got %b want %b", cyc, bus.M_RREADY, cyc == 10); end
                checks++; if (bus.req_rvalid !== 3'b100 || bus.req_rdata !== 32'h1234_5678) begin errors++; $display("FAIL stall_rdata c%0d: got %b/%h want 100/12345678", cyc, bus.req_rvalid, bus.req_rdata); end
            end else begin
                checks++; if (busy !== 1'b0 || bus.req_rvalid !== 3'b000) begin errors++; $display("FAIL stall_done: got busy=%b rvalid=%b want 0/000", busy, bus.req_rvalid); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_error();
        @(negedge aclk);
        bus.req_arvalid = 3'b010;
        bus.req_araddr  = {32'h0, 32'h0000_0044, 32'h0};
        bus.M_ARREADY   = 1'b1;
        bus.M_RVALID    = 1'b1;
        bus.M_RDATA     = 32'h0;
        bus.M_RRESP     = RESP_SLVERR;
        bus.req_rready  = 3'b111;
        #1;
        checks++; if (bus.req_arready !== 3'b010) begin errors++; $display("FAIL error_grant: got %b want 010", bus.req_arready); end
        @(negedge aclk);
        bus.req_arvalid = 3'b000;
        @(negedge aclk);
        #1;
        checks++; if (bus.req_rvalid !== 3'b010) begin errors++; $display("FAIL error_rvalid: got %b want 010", bus.req_rvalid); end
        checks++; if (bus.req_rresp !== RESP_SLVERR || bus.req_rdata !== 32'h0) begin errors++; $display("FAIL error_resp: got %b/%h want 10/00000000", bus.req_rresp, bus.req_rdata); end
        @(negedge aclk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_data();
        @(negedge aclk);
        bus.req_arvalid = 3'b100;
        bus.req_araddr  = {32'h0000_0300, 32'h0, 32'h0};
        bus.M_ARREADY   = 1'b1;
        bus.M_RVALID    = 1'b1;
        bus.M_RDATA     = 32'hA5A5_A5A5;
        @(negedge aclk);
        bus.req_arvalid = 3'b000;
        @(negedge aclk);
        #1;
        checks++; if (bus.req_rvalid !== 3'b100 || busy !== 1'b1) begin errors++; $display("FAIL rstdata_pre: got rvalid=%b busy=%b want 100/1", bus.req_rvalid, busy); end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checks++; if (bus.M_ARVALID !== 1'b0 || bus.M_RREADY !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstdata_outputs: got arv=%b rr=%b busy=%b want 0/0/0", bus.M_ARVALID, bus.M_RREADY, busy); end
        checks++; if (bus.req_rvalid !== 3'b000) begin errors++; $display("FAIL rstdata_rvalid: got %b want 000", bus.req_rvalid); end
        @(negedge aclk);
        aresetn         = 1'b0;
        bus.req_arvalid = 3'b011;
        bus.req_rready  = 3'b111;
        #1;
        checks++; if (bus.req_arready !== 3'b001) begin errors++; $display("FAIL rstdata_first_grant: got %b want 001", bus.req_arready); end
        @(negedge aclk);
        bus.req_arvalid = 3'b000;
        repeat (2) @(negedge aclk);
        clear_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0]  pend;
        logic [AW-1:0] addr_q [N];
        logic [N-1:0]  expv;
        int stage, cur, last, exp_g, served;
        logic [AW-1:0] cur_addr;
        aresetn = 1'b1;
        clear_inputs();
        @(negedge aclk);
        aresetn  = 1'b0;
        pend     = '0;
        stage    = 0;
        cur      = 0;
        cur_addr = '0;
        last     = N - 1;
        served   = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge aclk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    pend[i]   = 1'b1;
                    addr_q[i] = $urandom;
                end
                bus.req_araddr[i*AW +: AW] = addr_q[i];
            end
            bus.req_arvalid = pend;
            bus.M_ARREADY   = ($urandom_range(0, 9) < 6);
            bus.M_RVALID    = ($urandom_range(0, 9) < 6);
            bus.M_RDATA     = $urandom;
            bus.M_RRESP     = 2'($urandom_range(0, 3));
            bus.req_rready  = N'($urandom);
            #1;
            if (stage == 0) begin
                exp_g = rr_expect(pend, last);
                expv  = '0;
                if (exp_g >= 0) expv[exp_g] = 1'b1;
                checks++; if (bus.req_arready !== expv) begin errors++; $display("FAIL rand_arready c%0d: got %b want %b", cyc, bus.req_arready, expv); end
                checks++; if (busy !== 1'b0 || bus.M_ARVALID !== 1'b0 || bus.req_rvalid !== '0 || bus.M_RREADY !== 1'b0) begin errors++; $display("FAIL rand_idle c%0d: got busy=%b arv=%b rv=%b rr=%b want all 0", cyc, busy, bus.M_ARVALID, bus.req_rvalid, bus.M_RREADY); end
                if (exp_g >= 0) begin
                    cur       = exp_g;
                    cur_addr  = addr_q[cur];
                    pend[cur] = 1'b0;
                    stage     = 1;
                end
            end else if (stage == 1) begin
                checks++; if (bus.M_ARVALID !== 1'b1 || bus.M_ARADDR !== cur_addr) begin errors++; $display("FAIL rand_addr c%0d: got v=%b a=%h want v=1 a=%h", cyc, bus.M_ARVALID, bus.M_ARADDR, cur_addr); end
                checks++; if (grant_id !== IW'(cur) || bus.req_arready !== '0) begin errors++; $display("FAIL rand_grant c%0d: got id=%0d ar=%b want id=%0d ar=0", cyc, grant_id, bus.req_arready, cur); end
                if (bus.M_ARREADY) stage = 2;
            end else begin
                expv = '0;
                expv[cur] = bus.M_RVALID;
                checks++; if (bus.req_rvalid !== expv || bus.M_RREADY !== bus.req_rready[cur]) begin errors++; $display("FAIL rand_rsteer c%0d: got rv=%b rr=%b want rv=%b rr=%b", cyc, bus.req_rvalid, bus.M_RREADY, expv, bus.req_rready[cur]); end
                checks++; if (bus.req_rdata !== bus.M_RDATA || bus.req_rresp !== bus.M_RRESP) begin errors++; $display("FAIL rand_rdata c%0d: got %h/%b want %h/%b", cyc, bus.req_rdata, bus.req_rresp, bus.M_RDATA, bus.M_RRESP); end
                if (bus.M_RVALID && bus.req_rready[cur]) begin
                    last   = cur;
                    served = served + 1;
                    stage  = 0;
                end
            end
        end
        @(negedge aclk);
        clear_inputs();
        checks++; if (served < 50) begin errors++; $display("FAIL rand_progress: got %0d transactions want at least 50", served); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_stalls();
        test_error();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
